// File: rtl/xlr_sum_if.sv
// xlr_sum_engine bus bundle: GPP command/status and XLR_MEM port.
// slave = the engine side, master = the GPP host / memory side.
interface xlr_sum_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              gpp_start;
  logic [ADDR_W-1:0] gpp_base;
  logic [ADDR_W:0]   gpp_len;
  logic [ADDR_W-1:0] gpp_res_addr;
  logic              gpp_busy;
  logic              gpp_done;
  logic [DATA_W-1:0] gpp_result;
  logic              gpp_ovf;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  gpp_start, gpp_base, gpp_len, gpp_res_addr, mem_rdata,
    output gpp_busy, gpp_done, gpp_result, gpp_ovf,
    output mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output gpp_start, gpp_base, gpp_len, gpp_res_addr, mem_rdata,
    input  gpp_busy, gpp_done, gpp_result, gpp_ovf,
    input  mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/xlr_sum_engine.sv
// Accelerator sum core: streams a block from XLR_MEM, writes the sum back.
// Optional XLR_SUM_SAT_EN: saturating accumulate with sticky gpp_ovf.
module xlr_sum_engine #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     rst_n,
  xlr_sum_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, WRITE, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   C_ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              acc_en_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] acc_add;
  logic              clip;

`ifdef XLR_SUM_SAT_EN
  logic [DATA_W:0] sum;

  // saturating add of the returning read word
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, bus.mem_rdata};
    clip    = sum[DATA_W];
    acc_add = clip ? '1 : sum[DATA_W-1:0];
  end
`else
  // wrapping add of the returning read word
  always_comb begin
    clip    = 1'b0;
    acc_add = acc_q + bus.mem_rdata;
  end
`endif

  // next state and next registered outputs
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    acc_d    = acc_en_q ? acc_add : acc_q;
    ovf_d    = ovf_q | (acc_en_q & clip);
    unique case (state_q)
      IDLE: begin
        if (bus.gpp_start) begin
          len_d    = bus.gpp_len;
          res_d    = bus.gpp_res_addr;
          acc_d    = '0;
          done_d   = 1'b0;
          ovf_d    = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          if (bus.gpp_len != '0) begin
            state_d = READ;
            rd_d    = 1'b1;
            addr_d  = bus.gpp_base;
            cnt_d   = C_ONE;
          end else begin
            state_d = WRITE;
            wr_d    = 1'b1;
            addr_d  = bus.gpp_res_addr;
          end
        end
      end
      READ: begin
        if (cnt_q == len_q) begin
          state_d = DRAIN;
        end else begin
          rd_d   = 1'b1;
          addr_d = addr_q + A_ONE;
          cnt_d  = cnt_q + C_ONE;
        end
      end
      DRAIN: begin
        state_d = WRITE;
        wr_d    = 1'b1;
        addr_d  = res_q;
        wdata_d = acc_d;
      end
      WRITE: begin
        state_d  = DONE;
        result_d = acc_q;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      acc_q    <= '0;
      acc_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      acc_q    <= acc_d;
      acc_en_q <= rd_q;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.gpp_busy   = busy_q;
  assign bus.gpp_done   = done_q;
  assign bus.gpp_result = result_q;
  assign bus.gpp_ovf    = ovf_q;
  assign bus.mem_rd     = rd_q;
  assign bus.mem_wr     = wr_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

endmodule

// File: doc/xlr_sum_engine.md
# xlr_sum_engine

Accelerator compute core of the HoneyB SoC, sitting between the general-purpose port (GPP) register interface and the accelerator memory (XLR_MEM) bank. On a GPP start command it streams a block of words out of XLR_MEM, accumulates them, writes the sum back to a result address in XLR_MEM and reports completion on GPP. It is the DUT stage driven by the xlr_gpp agent and serviced by the xlr_mem agent in the top-level test environment.

## Interface
Clock `clk`; reset `rst_n`, asynchronous, active-low.
- ADDR_W, 5, XLR_MEM word-address width
- DATA_W, 32, data and accumulator width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- gpp_start  in  1  start pulse, sampled in IDLE only
- gpp_base  in  ADDR_W  first read address
- gpp_len  in  ADDR_W+1  word count, 0..2^ADDR_W
- gpp_res_addr  in  ADDR_W  result write address
- gpp_busy  out  1  high from cycle after accepted start until DONE
- gpp_done  out  1  sticky completion flag
- gpp_result  out  DATA_W  final sum, held until next accepted start
- gpp_ovf  out  1  saturation flag (see Configuration)
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe
- mem_addr  out  ADDR_W  read/write address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: gpp_start=1 latches base, len, res_addr; clears acc, gpp_done, gpp_ovf, gpp_result; goes READ if len>0, else WRITE.
- READ: one mem_rd per cycle, mem_addr = base+i (mod 2^ADDR_W, wraps), i = 0..len-1; after i=len-1 goes DRAIN.
- Each cycle following a mem_rd: acc <= acc + mem_rdata (DATA_W bits, wraps mod 2^DATA_W unless macro defined).
- DRAIN: accumulates final word, no strobes.
- WRITE: mem_wr=1, mem_addr=res_addr, mem_wdata=acc (0 when len=0); gpp_result <= acc.
- DONE: gpp_done <= 1, gpp_busy <= 0; next cycle IDLE. gpp_done stays 1 until next accepted start.
- gpp_start while not IDLE: ignored, no effect on latched values.
- mem_rd and mem_wr never asserted in the same cycle; mem_addr/mem_wdata are 0 when no strobe.
- Inputs gpp_base/len/res_addr only sampled on accepted start; later changes ignored.

## Timing
- Reset: state IDLE; gpp_busy, gpp_done, gpp_ovf, gpp_result, mem_rd, mem_wr, mem_addr, mem_wdata all 0; acc 0.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no partial write.
- Start accepted at edge 0 (len=L>0): busy=1 and first mem_rd in cycle 1; last mem_rd in cycle L; DRAIN cycle L+1; mem_wr cycle L+2; done=1, busy=0 from cycle L+3.
- len=0: mem_wr in cycle 1, done from cycle 2.
- New start accepted earliest in the cycle after DONE (IDLE).
- All outputs registered.

## Configuration
- XLR_SUM_SAT_EN defined: accumulation saturates at 2^DATA_W-1; any clipping sets gpp_ovf=1, held until next accepted start; written result is the saturated value.
- XLR_SUM_SAT_EN undefined: accumulation wraps modulo 2^DATA_W; gpp_ovf tied 0.

## Test plan
- Basic: mem[4..7]={1,2,3,4}, base=4, len=4, res_addr=20, start -> 4 reads addr 4..7 in cycles 1..4, mem_wr addr 20 data 10 in cycle 6, done=1/busy=0 in cycle 7, gpp_result=10.
- Zero length: len=0, res_addr=3 -> mem_wr addr 3 data 0 in cycle 1, done in cycle 2, no mem_rd.
- Wrap-around: base=30, len=4, ADDR_W=5 -> read addrs 30,31,0,1; sum correct.
- Overflow: two words 0xFFFFFFFF, 0x00000002 -> without macro result 0x00000001, ovf=0; with XLR_SUM_SAT_EN result 0xFFFFFFFF, ovf=1.
- Start while busy: second gpp_start (different base/len) in cycle 2 of a len=8 job -> ignored, original job completes unchanged; done remains 1 until a start in IDLE clears it.
- Reset mid-READ: rst_n low in cycle 3 -> all outputs 0 immediately, no mem_wr; a subsequent normal job completes correctly.
